// File: rtl/equation_sequencer_pkg.sv
// Shared types and widths for the equation puzzle round controller.
package equation_sequencer_pkg;

  localparam int TIMER_W = 7;  // seconds counters (OngoingTimer, secs_left)
  localparam int CNT_W   = 4;  // score and round counters

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/equation_sequencer_sec_timebase.sv
// Seconds timebase: prescaler producing a one-cycle sec_tick and a wrapping
// free-running seconds counter shown to the players.
import equation_sequencer_pkg::*;

module sec_timebase #(
  parameter int TICK_DIV   = 50000000,
  parameter int TIMER_WRAP = 100
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic               sec_tick,
  output logic [TIMER_W-1:0] OngoingTimer
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign sec_tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc        <= '0;
      OngoingTimer <= '0;
    end else begin
      presc <= sec_tick ? '0 : presc + 1'b1;
      if (sec_tick)
        OngoingTimer <= (OngoingTimer == TIMER_W'(TIMER_WRAP - 1)) ? '0 : OngoingTimer + 1'b1;
    end
  end

endmodule

// File: rtl/equation_sequencer.sv
// Round controller for the equation puzzle bank: arms one equation per round,
// enforces the time limit, keeps score and ends the game after MAX_ROUNDS.
import equation_sequencer_pkg::*;

module equation_sequencer #(
  parameter int NUM_EQ     = 3,
  parameter int TICK_DIV   = 50000000,
  parameter int ROUND_SECS = 30,
  parameter int MAX_ROUNDS = 5,
  parameter int TIMER_WRAP = 100
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               StartGame,
  input  logic               Retry,
  input  logic               Go,
  input  logic [NUM_EQ-1:0]  eq_correct,
  output logic [NUM_EQ-1:0]  eq_start,
  output logic [NUM_EQ-1:0]  eq_go,
  output logic [TIMER_W-1:0] OngoingTimer,
  output logic [1:0]         active_eq,
  output logic [CNT_W-1:0]   round_num,
  output logic [TIMER_W-1:0] secs_left,
  output logic [CNT_W-1:0]   score,
  output logic               timeout,
  output logic               game_over
);

  if (NUM_EQ < 2 || NUM_EQ > 4) begin : g_bad_num_eq
    $error("equation_sequencer: NUM_EQ must be 2..4");
  end
  if (ROUND_SECS < 1 || ROUND_SECS > 127 || MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_round
    $error("equation_sequencer: ROUND_SECS or MAX_ROUNDS out of range");
  end

  state_t            state, state_nxt;
  logic              sec_tick;
  logic              prev_correct;
  logic [NUM_EQ-1:0] sel;
  logic              cur_correct, win_edge, retry_fire, start_now;

  sec_timebase #(.TICK_DIV(TICK_DIV), .TIMER_WRAP(TIMER_WRAP)) u_timebase (
    .Clock        (Clock),
    .Reset        (Reset),
    .sec_tick     (sec_tick),
    .OngoingTimer (OngoingTimer)
  );

  // Only the active equation's flag matters; a level held from before ARM
  // never counts, only a fresh rising edge does.
  assign sel         = NUM_EQ'(1) << active_eq;
  assign cur_correct = |(eq_correct & sel);
  assign win_edge    = (state == S_PLAY) && cur_correct && !prev_correct;
  assign retry_fire  = (state == S_PLAY) && Retry && !win_edge;
  assign start_now   = (state == S_ARM) || (state == S_WIN) || retry_fire;

  assign eq_start  = start_now ? sel : '0;
  assign eq_go     = (Go && state == S_PLAY) ? sel : '0;
  assign timeout   = (state == S_LOSE);
  assign game_over = (state == S_DONE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (StartGame) state_nxt = S_ARM;
      S_ARM:  state_nxt = S_PLAY;
      S_PLAY: begin
        if (win_edge)                                      state_nxt = S_WIN;
        else if (sec_tick && secs_left == TIMER_W'(1))     state_nxt = S_LOSE;
      end
      S_WIN, S_LOSE: state_nxt = S_NEXT;
      S_NEXT: state_nxt = (round_num == CNT_W'(MAX_ROUNDS - 1)) ? S_DONE : S_ARM;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      secs_left    <= '0;
      score        <= '0;
      round_num    <= '0;
      active_eq    <= '0;
      prev_correct <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (StartGame) begin
          score     <= '0;
          round_num <= '0;
          active_eq <= '0;
        end
        S_ARM: begin
          secs_left    <= TIMER_W'(ROUND_SECS);
          prev_correct <= cur_correct;
        end
        S_PLAY: begin
          prev_correct <= cur_correct;
          if (sec_tick && secs_left != '0) secs_left <= secs_left - 1'b1;
        end
        S_WIN:  if (score != '1) score <= score + 1'b1;
        S_LOSE: secs_left <= '0;
        S_NEXT: if (round_num != CNT_W'(MAX_ROUNDS - 1)) begin
          round_num <= round_num + 1'b1;
          active_eq <= (active_eq == 2'(NUM_EQ - 1)) ? 2'd0 : active_eq + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
